// File: rtl/uart_tx_arbiter_if.sv
// Bundle between up to four byte requesters, one UART transmitter and the arbiter.
// i_* are driven into the arbiter, o_* are driven by it.
interface uart_tx_arbiter_if;
  logic [3:0]  i_req;
  logic [31:0] i_din;
  logic        i_tx_rdy;
  logic        i_clr_ovr;
  logic        o_tx_load;
  logic [7:0]  o_tx_data;
  logic [3:0]  o_grant;
  logic [3:0]  o_done;
  logic [3:0]  o_ovr;
  logic        o_busy;

  modport slave (
    input  i_req, i_din, i_tx_rdy, i_clr_ovr,
    output o_tx_load, o_tx_data, o_grant, o_done, o_ovr, o_busy
  );

  modport master (
    output i_req, i_din, i_tx_rdy, i_clr_ovr,
    input  o_tx_load, o_tx_data, o_grant, o_done, o_ovr, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single UART transmitter.
// Each requester gets a one-byte holding register and a sticky overrun flag.
module uart_tx_arbiter (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_cur;
  logic [1:0] w_cur_next;
  logic [1:0] r_last;
  logic [1:0] w_last_next;
  logic [3:0] r_done;
  logic [3:0] w_done_next;

  logic [3:0] r_q1;
  logic [3:0] r_q2;
  logic [3:0] w_ped;
  logic [3:0] r_pending;
  logic [3:0] r_ovr;
  logic [7:0] r_hold [4];
  logic [7:0] w_din_byte [4];

  logic [3:0] w_clear;
  logic [3:0] w_pend_eff;
  logic [3:0] w_capture;
  logic [3:0] w_overrun;
  logic [1:0] w_sel;
  logic       w_sel_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_din
      assign w_din_byte[gi] = bus.i_din[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q1 <= 4'b0000;
      r_q2 <= 4'b0000;
    end else begin
      r_q1 <= bus.i_req;
      r_q2 <= r_q1;
    end
  end

  assign w_ped = r_q1 & ~r_q2;

  // The channel being loaded counts as free this cycle, so a coincident edge re-arms it cleanly.
  assign w_clear    = (r_state == S_LOAD) ? (4'b0001 << r_cur) : 4'b0000;
  assign w_pend_eff = r_pending & ~w_clear;
  assign w_capture  = w_ped & ~w_pend_eff;
  assign w_overrun  = w_ped & w_pend_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 4'b0000;
      r_ovr     <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= 8'h00;
      end
    end else begin
      r_pending <= w_pend_eff | w_capture;
      r_ovr     <= (r_ovr & {4{~bus.i_clr_ovr}}) | w_overrun;
      for (int i = 0; i < 4; i++) begin
        if (w_capture[i]) begin
          r_hold[i] <= w_din_byte[i];
        end
      end
    end
  end

  // Scan from farthest to nearest so the nearest pending channel after r_last wins.
  always_comb begin
    w_sel       = r_last;
    w_sel_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (r_pending[r_last + 2'(k)]) begin
        w_sel       = r_last + 2'(k);
        w_sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cur   <= 2'd0;
      r_last  <= 2'd3;
      r_done  <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_cur   <= w_cur_next;
      r_last  <= w_last_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    w_last_next  = r_last;
    w_done_next  = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (bus.i_tx_rdy && w_sel_valid) begin
          w_state_next = S_LOAD;
          w_cur_next   = w_sel;
          w_last_next  = w_sel;
        end
      end
      S_LOAD: begin
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.i_tx_rdy) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.i_tx_rdy) begin
          w_state_next = S_IDLE;
          w_done_next  = 4'b0001 << r_cur;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.o_tx_load = (r_state == S_LOAD);
  assign bus.o_tx_data = (r_state == S_LOAD) ? r_hold[r_cur] : 8'h00;
  assign bus.o_grant   = (r_state != S_IDLE) ? (4'b0001 << r_cur) : 4'b0000;
  assign bus.o_done    = r_done;
  assign bus.o_ovr     = r_ovr;
  assign bus.o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter; the bench plays the UART and
// predicts the send order from the round-robin rule at transaction level.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for the load strobe, check the presented byte, then step into WAIT_BUSY.
  task automatic take_load(input int ch, input logic [7:0] b, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_tx_load && lat < 40);
    check($sformatf("load_ch%0d", ch), bus.o_tx_load, 1);
    check($sformatf("data_ch%0d", ch), bus.o_tx_data, b);
    check($sformatf("grant_ch%0d", ch), bus.o_grant, 32'd1 << ch);
    check("busy_load", bus.o_busy, 1);
    $display("txn: ch%0d data=%02h latency=%0d", ch, bus.o_tx_data, lat);
    @(negedge clk);
    check("load_one_cycle", bus.o_tx_load, 0);
    check("data_zero", bus.o_tx_data, 0);
  endtask

  // UART shifts for n cycles, then returns ready; done must pulse on the first idle cycle.
  task automatic finish_byte(input int ch, input int n);
    bus.i_tx_rdy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("grant_hold", bus.o_grant, 32'd1 << ch);
    end
    bus.i_tx_rdy = 1'b1;
    @(negedge clk);
    check($sformatf("done_ch%0d", ch), bus.o_done, 32'd1 << ch);
    check("busy_idle", bus.o_busy, 0);
    check("grant_idle", bus.o_grant, 0);
  endtask

  int         lat;
  int         order[$];
  int         last_ch;
  int         ovr_ch;
  int         ch;
  logic [3:0] set;
  logic [3:0] exp_ovr;
  logic [7:0] bytes [4];
  logic       seen;

  initial begin
    reset         = 1'b1;
    bus.i_req     = 4'b0000;
    bus.i_din     = 32'h0;
    bus.i_tx_rdy  = 1'b1;
    bus.i_clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_load", bus.o_tx_load, 0);
    check("rst_tx_data", bus.o_tx_data, 0);
    check("rst_grant", bus.o_grant, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_ovr", bus.o_ovr, 0);
    reset = 1'b0;

    // Single send on channel 2
    do_reset();
    bus.i_din[23:16] = 8'hA5;
    bus.i_req[2]     = 1'b1;
    take_load(2, 8'hA5, lat);
    check("latency_single", lat, 3);
    finish_byte(2, 10);
    @(negedge clk);
    check("done_one_cycle", bus.o_done, 0);
    bus.i_req = 4'b0000;

    // Round-robin: ch0, ch1, ch3, then ch0 re-requested during ch3
    do_reset();
    bus.i_din = {8'h44, 8'h00, 8'h22, 8'h11};
    bus.i_req = 4'b1011;
    take_load(0, 8'h11, lat);
    bus.i_req = 4'b0000;
    finish_byte(0, 4);
    take_load(1, 8'h22, lat);
    finish_byte(1, 4);
    take_load(3, 8'h44, lat);
    bus.i_din[7:0] = 8'h55;
    bus.i_req[0]   = 1'b1;
    finish_byte(3, 4);
    take_load(0, 8'h55, lat);
    finish_byte(0, 3);
    bus.i_req = 4'b0000;

    // Overrun while the transmitter is busy
    do_reset();
    bus.i_tx_rdy    = 1'b0;
    bus.i_din[15:8] = 8'h10;
    bus.i_req[1]    = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_req[1] = 1'b0;
    repeat (2) @(negedge clk);
    bus.i_din[15:8] = 8'h20;
    bus.i_req[1]    = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_set", bus.o_ovr, 4'b0010);
    check("ovr_still_idle", bus.o_busy, 0);
    bus.i_tx_rdy = 1'b1;
    take_load(1, 8'h10, lat);
    finish_byte(1, 3);
    bus.i_req = 4'b0000;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.o_tx_load;
    end
    check("ovr_no_second_load", seen, 0);
    check("ovr_sticky", bus.o_ovr, 4'b0010);
    bus.i_clr_ovr = 1'b1;
    @(negedge clk);
    bus.i_clr_ovr = 1'b0;
    check("ovr_cleared", bus.o_ovr, 0);

    // Set wins: a fresh edge on ch3 lands in the LOAD cycle of ch3
    do_reset();
    bus.i_din[31:24] = 8'h33;
    bus.i_req[3]     = 1'b1;
    @(negedge clk);
    bus.i_req[3] = 1'b0;
    @(negedge clk);
    bus.i_din[31:24] = 8'h77;
    bus.i_req[3]     = 1'b1;
    take_load(3, 8'h33, lat);
    check("setwin_latency", lat, 1);
    check("setwin_no_ovr", bus.o_ovr, 0);
    finish_byte(3, 3);
    take_load(3, 8'h77, lat);
    finish_byte(3, 3);
    check("setwin_no_ovr_end", bus.o_ovr, 0);
    bus.i_req = 4'b0000;

    // Reset during WAIT_DONE abandons the byte
    do_reset();
    bus.i_din[7:0] = 8'h99;
    bus.i_req[0]   = 1'b1;
    take_load(0, 8'h99, lat);
    bus.i_req    = 4'b0000;
    bus.i_tx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus.o_busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_grant", bus.o_grant, 0);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_done", bus.o_done, 0);
    @(negedge clk);
    bus.i_tx_rdy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.o_tx_load | (|bus.o_done);
    end
    check("midrst_quiet", seen, 0);

    // Request held high across reset release counts as an edge
    @(negedge clk);
    reset            = 1'b1;
    bus.i_din[23:16] = 8'hC3;
    bus.i_req        = 4'b0100;
    @(negedge clk);
    reset = 1'b0;
    take_load(2, 8'hC3, lat);
    check("held_req_latency", lat, 3);
    finish_byte(2, 2);
    bus.i_req = 4'b0000;

    // Randomized rounds against the round-robin order model
    do_reset();
    last_ch = 3;
    for (int r = 0; r < 25; r++) begin
      repeat (2) @(negedge clk);
      set = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        bytes[c] = 8'($urandom);
        bus.i_din[8*c +: 8] = bytes[c];
      end
      order.delete();
      for (int k = 1; k <= 4; k++) begin
        if (set[(last_ch + k) % 4]) order.push_back((last_ch + k) % 4);
      end
      ovr_ch  = -1;
      exp_ovr = 4'b0000;
      if (order.size() >= 2 && ($urandom % 2) == 1) begin
        ovr_ch  = order[order.size() - 1];
        exp_ovr = 4'b0001 << ovr_ch;
      end
      bus.i_req = set;
      for (int i = 0; i < order.size(); i++) begin
        ch = order[i];
        take_load(ch, bytes[ch], lat);
        if (i == 0) check("rand_latency", lat, 3);
        if (i == 0 && ovr_ch >= 0) begin
          bus.i_req[ovr_ch] = 1'b0;
          bus.i_din[8*ovr_ch +: 8] = ~bytes[ovr_ch];
          @(negedge clk);
          bus.i_req[ovr_ch] = 1'b1;
        end
        finish_byte(ch, int'($urandom_range(2, 6)));
      end
      check($sformatf("rand_ovr_r%0d", r), bus.o_ovr, exp_ovr);
      bus.i_req     = 4'b0000;
      bus.i_clr_ovr = 1'b1;
      @(negedge clk);
      bus.i_clr_ovr = 1'b0;
      check("rand_ovr_clr", bus.o_ovr, 0);
      last_ch = order[order.size() - 1];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 4 and data width at 8.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester send request; rising edge = one byte to send.
REQ-005 din  input  32  requester bytes, channel i on din[8i+7:8i].
REQ-006 tx_rdy  input  1  UART transmitter idle (1) / shifting (0).
REQ-007 clr_ovr  input  1  synchronous clear of all overrun flags.
REQ-008 tx_load  output  1  one-cycle load strobe to transmitter.
REQ-009 tx_data  output  8  byte presented to transmitter, valid while tx_load=1.
REQ-010 grant  output  4  one-hot channel currently owning the transmitter; 0 when idle.
REQ-011 done  output  4  one-cycle pulse on channel i when its byte finishes (tx_rdy returns high).
REQ-012 ovr  output  4  sticky overrun flag per channel.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Each req bit SHALL pass through a 2-flop register pair; ped[i] = Q1 & ~Q2, combinational, one cycle wide.
REQ-015 On ped[i]=1 with pending[i]=0, pending[i] SHALL set and hold[i] SHALL capture din byte i at the same clock edge.
REQ-016 On ped[i]=1 with pending[i]=1, ovr[i] SHALL set, and hold[i] and pending[i] SHALL remain unchanged (new byte dropped).
REQ-017 A ped[i] in the same cycle that pending[i] is cleared by LOAD SHALL set pending[i], capture new data, and SHALL NOT set ovr[i] (set wins).
REQ-018 clr_ovr=1 SHALL clear ovr to 0 at the next edge; a simultaneous overrun event SHALL win (flag stays 1).
REQ-019 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> LOAD when tx_rdy=1 and pending!=0; the selected channel SHALL be latched into cur and into last.
REQ-021 Selection SHALL be round-robin: search order last+1, last+2, last+3, last (mod 4); first pending found wins.
REQ-022 In LOAD (exactly one cycle): tx_load=1, tx_data=hold[cur], pending[cur] cleared; next state WAIT_BUSY.
REQ-023 WAIT_BUSY -> WAIT_DONE when tx_rdy=0; WAIT_DONE -> IDLE when tx_rdy=1, with done[cur]=1 for that one cycle (registered, asserted in the first IDLE cycle).
REQ-024 grant SHALL equal one-hot(cur) in LOAD, WAIT_BUSY, WAIT_DONE, and 0 in IDLE.
REQ-025 tx_load, grant and done SHALL be registered or decoded from registered state only (glitch-free).
REQ-026 Latency: req rising sampled at edge k -> pending set at edge k+1 -> LOAD entered at edge k+2 (tx_rdy=1, no other pending) -> tx_load high in cycle after k+2.
REQ-027 tx_data SHALL be 8'h00 whenever tx_load=0.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE, cur=0, last=3, pending=0, hold=0, ovr=0, Q1=Q2=0.
REQ-029 During and after reset: tx_load=0, tx_data=8'h00, grant=0, done=0, busy=0; a reset mid-transfer SHALL abandon the byte without done.
REQ-030 A req held high through reset release SHALL register as a rising edge on the first sampled cycle.

Verification
REQ-031 Single send: req[2] 0->1, din byte2=8'hA5, tx_rdy=1 -> tx_load one cycle at k+3, tx_data=A5, grant=4'b0100; tx_rdy 0 for 10 cycles then 1 -> done=4'b0100 one cycle, busy=0.
REQ-032 Round-robin: req[0], req[1], req[3] rise in same cycle (bytes 11, 22, 44) after reset -> transmit order ch0, ch1, ch3; with ch0 re-requested during ch3 -> ch0 follows ch3.
REQ-033 Overrun: req[1] rises (8'h10), falls, rises (8'h20) while tx_rdy=0 -> ovr=4'b0010, byte sent is 8'h10; clr_ovr pulse -> ovr=0.
REQ-034 Set-wins: ped[3] coincident with LOAD of ch3 -> ovr[3]=0, second byte sent on next arbitration.
REQ-035 Reset mid-operation: assert reset in WAIT_DONE -> grant=0, busy=0, no done pulse, pending=0 immediately (asynchronous).
